step_controller: RTL and testbench



---
 rtl/step_controller_pkg.sv | 20 ++
 rtl/step_controller_if.sv | 22 ++
 rtl/step_controller_debouncer.sv | 84 ++++++++
 rtl/step_controller.sv | 92 +++++++++
 tb/tb_step_controller.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/step_controller_pkg.sv
// Shared types and constants for the step controller: debounce state encoding,
// default timing parameters and counter widths.
package step_ctrl_pkg;

  localparam int     DEBOUNCE_CYCLES_DEF = 500000;
  localparam longint RUN_DIV_DEF         = 64'd50000000;

  localparam int CNT_W      = 24;
  localparam int PRESCALE_W = 32;
  localparam int STEP_W     = 16;
  localparam int SW_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } deb_state_t;

endpackage

// File: rtl/step_controller_if.sv
// Front-panel bundle between the board pins/testbench and the step controller.
interface step_controller_if;
  import step_ctrl_pkg::*;

  logic              btn_step;
  logic [SW_W-1:0]   sw_raw;
  logic              run_mode;
  logic              step_pulse;
  logic [SW_W-1:0]   switches_sync;
  logic [STEP_W-1:0] step_count;

  modport master (
    output btn_step, sw_raw, run_mode,
    input  step_pulse, switches_sync, step_count
  );

  modport slave (
    input  btn_step, sw_raw, run_mode,
    output step_pulse, switches_sync, step_count
  );

endinterface

// File: rtl/step_controller_debouncer.sv
// Step-button synchronizer and debounce FSM; press_evt is high for one cycle
// (combinationally, from registered state) when a press has been qualified.
module btn_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign btn_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A press fires once on entry to HELD; a bounce back during release returns to HELD silently.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end
      end
      REL_CHK: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/step_controller.sv
// Step controller: debounced single-cycle step enable, switch sync and step counter.
// Define STEP_CONTROLLER_AUTO_RUN_EN to build the run_mode auto-step prescaler.
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter longint RUN_DIV         = RUN_DIV_DEF
) (
  input logic              clk,
  input logic              reset,
  step_controller_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] RUN_TERM = PRESCALE_W'(RUN_DIV - 1);

  logic              btn_evt;
  logic              pulse_nxt;
  logic              step_pulse_q;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [STEP_W-1:0] count_q;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (bus.btn_step),
    .press_evt(btn_evt)
  );

`ifdef STEP_CONTROLLER_AUTO_RUN_EN
  logic                  run_meta;
  logic                  run_s;
  logic                  run_fire;
  logic [PRESCALE_W-1:0] pre_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      run_meta <= bus.run_mode;
      run_s    <= run_meta;
    end
  end

  assign run_fire = run_s && (pre_q == RUN_TERM);

  // Leaving run mode parks the prescaler at zero so the next run starts a full period.
  always_ff @(posedge clk) begin
    if (reset || !run_s || run_fire) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRESCALE_W'(1);
    end
  end

  always_comb begin
    pulse_nxt = btn_evt;
    if (run_s) begin
      pulse_nxt = run_fire;
    end
  end
`else
  logic [PRESCALE_W:0] unused_run;
  assign unused_run = {bus.run_mode, RUN_TERM};

  always_comb begin
    pulse_nxt = btn_evt;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      step_pulse_q <= 1'b0;
      count_q      <= '0;
      sw_meta      <= '0;
      sw_sync      <= '0;
    end else begin
      step_pulse_q <= pulse_nxt;
      count_q      <= count_q + STEP_W'(step_pulse_q);
      sw_meta      <= bus.sw_raw;
      sw_sync      <= sw_meta;
    end
  end

  assign bus.step_pulse    = step_pulse_q;
  assign bus.switches_sync = sw_sync;
  assign bus.step_count    = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller with DEBOUNCE_CYCLES=4, RUN_DIV=5;
// a run-length model of press/release qualification is compared every cycle.
module tb_step_controller;
  import step_ctrl_pkg::*;

  localparam int     D  = 4;
  localparam longint RD = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  step_controller_if bus();

  step_controller #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (RD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs after the most recent rising edge.
  logic        exp_pulse = 1'b0;
  logic [15:0] exp_count = '0;
  logic [2:0]  exp_sw    = '0;

  logic       m_s1, m_s2, m_armed;
  logic [2:0] m_w1;
  int         m_ones, m_zeros;
`ifdef STEP_CONTROLLER_AUTO_RUN_EN
  logic       m_r1, m_r2;
  longint     m_pre;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // A press is accepted once D+1 consecutive high samples arrive while armed;
  // re-arming needs D+1 consecutive low samples.
  task automatic model_step();
    logic pulse;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_w1 = '0; m_armed = 1'b1;
      m_ones = 0; m_zeros = 0;
      exp_pulse = 1'b0; exp_count = '0; exp_sw = '0;
`ifdef STEP_CONTROLLER_AUTO_RUN_EN
      m_r1 = 1'b0; m_r2 = 1'b0; m_pre = 0;
`endif
    end else begin
      pulse = 1'b0;
      if (m_s2) begin
        m_ones++;
        m_zeros = 0;
        if (m_armed && m_ones == D + 1) begin
          pulse   = 1'b1;
          m_armed = 1'b0;
        end
      end else begin
        m_zeros++;
        m_ones = 0;
        if (!m_armed && m_zeros == D + 1) m_armed = 1'b1;
      end
`ifdef STEP_CONTROLLER_AUTO_RUN_EN
      if (m_r2) begin
        m_pre++;
        pulse = (m_pre == RD);
        if (pulse) m_pre = 0;
      end else begin
        m_pre = 0;
      end
      m_r2 = m_r1;
      m_r1 = bus.run_mode;
`endif
      exp_count = exp_count + 16'(exp_pulse);
      exp_pulse = pulse;
      exp_sw    = m_w1;
      m_w1      = bus.sw_raw;
      m_s2      = m_s1;
      m_s1      = bus.btn_step;
    end
  endtask

  initial begin
    m_s1 = 1'b0; m_s2 = 1'b0; m_w1 = '0; m_armed = 1'b1; m_ones = 0; m_zeros = 0;
`ifdef STEP_CONTROLLER_AUTO_RUN_EN
    m_r1 = 1'b0; m_r2 = 1'b0; m_pre = 0;
`endif
    forever begin
      @(negedge clk);
      checkOutput("model_pulse", 32'(bus.step_pulse), 32'(exp_pulse));
      checkOutput("model_count", 32'(bus.step_count), 32'(exp_count));
      checkOutput("model_sw", 32'(bus.switches_sync), 32'(exp_sw));
      model_step();
    end
  end

  task automatic applyStimulus(input logic rst_v, input logic btn_v, input logic [2:0] sw_v,
                               input logic run_v, input int ncycles);
    reset        = rst_v;
    bus.btn_step = btn_v;
    bus.sw_raw   = sw_v;
    bus.run_mode = run_v;
    repeat (ncycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watchPulse(input int pulse_edge, input int nedges);
    for (int k = 0; k < nedges; k++) begin
      @(posedge clk);
      #1;
      checkOutput("press_edge", 32'(bus.step_pulse), 32'(k == pulse_edge));
    end
  endtask

  task automatic countPulses(input int ncycles, output int n);
    n = 0;
    for (int k = 0; k < ncycles; k++) begin
      @(posedge clk);
      #1;
      n += int'(bus.step_pulse);
    end
  endtask

  task automatic runBtnPattern(input logic [7:0] pat, input int len, input int tail, output int n);
    int extra;
    n = 0;
    for (int i = 0; i < len; i++) begin
      bus.btn_step = pat[len-1-i];
      @(posedge clk);
      #1;
      n += int'(bus.step_pulse);
    end
    countPulses(tail, extra);
    n += extra;
  endtask

  initial begin
    int n1, n2;
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 3);
    checkOutput("reset_pulse", 32'(bus.step_pulse), 32'd0);
    checkOutput("reset_count", 32'(bus.step_count), 32'd0);
    checkOutput("reset_sw", 32'(bus.switches_sync), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 3);

    $display("[TB] clean press");
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 0);
    watchPulse(6, 20);
    checkOutput("count_after_press", 32'(bus.step_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 10);

    $display("[TB] press and release bounce");
    runBtnPattern(8'b11011111, 8, 6, n1);
    checkOutput("bounce_press_pulses", 32'(n1), 32'd1);
    runBtnPattern(8'b00010000, 6, 8, n2);
    checkOutput("bounce_release_pulses", 32'(n2), 32'd0);
    checkOutput("fsm_idle", 32'(dut.u_deb.state), 32'(IDLE));
    checkOutput("count_after_bounce", 32'(bus.step_count), 32'd2);

    $display("[TB] switch sync latency");
    applyStimulus(1'b0, 1'b0, 3'b101, 1'b0, 1);
    checkOutput("sw_edge1", 32'(bus.switches_sync), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b101, 1'b0, 1);
    checkOutput("sw_edge2", 32'(bus.switches_sync), 32'b101);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 1);
    checkOutput("sw_edge1b", 32'(bus.switches_sync), 32'b101);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 1);
    checkOutput("sw_edge2b", 32'(bus.switches_sync), 32'b010);

    $display("[TB] reset mid-press");
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b010, 1'b0, 1);
      checkOutput("inreset_pulse", 32'(bus.step_pulse), 32'd0);
      checkOutput("inreset_count", 32'(bus.step_count), 32'd0);
      checkOutput("inreset_sw", 32'(bus.switches_sync), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 0);
    watchPulse(6, 12);
    checkOutput("count_after_reset_press", 32'(bus.step_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 10);

    $display("[TB] counter wrap");
    force dut.count_q = 16'hFFFE;
    exp_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.count_q;
    checkOutput("count_preload", 32'(bus.step_count), 32'hFFFE);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 10);
    checkOutput("count_ffff", 32'(bus.step_count), 32'hFFFF);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 10);
    checkOutput("count_wrap", 32'(bus.step_count), 32'h0000);

`ifdef STEP_CONTROLLER_AUTO_RUN_EN
    $display("[TB] auto-run");
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b1, 0);
    countPulses(3, n1);
    bus.btn_step = 1'b1;
    countPulses(22, n2);
    checkOutput("autorun_pulses", 32'(n1 + n2), 32'd4);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 0);
    countPulses(4, n1);
    checkOutput("prescaler_cleared", dut.pre_q, 32'd0);
    countPulses(15, n2);
    checkOutput("autorun_stopped", 32'(n2), 32'd0);
`else
    $display("[TB] run_mode ignored");
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b1, 0);
    watchPulse(6, 12);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 10);
    checkOutput("count_run_ignored", 32'(bus.step_count), 32'h0001);
`endif

    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
